// File: rtl/mux_n_1_rr.sv
// N-channel registered mux with fixed-select or round-robin arbitration.
// Optional even-parity output enabled by defining MUXN_PARITY_EN.
module mux_n_1_rr #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mode,
  input  logic [SELW-1:0] i_sel,
  input  logic [N-1:0]    i_in_valid,
  input  logic [N*W-1:0]  i_in_data,
  output logic [N-1:0]    o_in_ready,
  output logic            o_out_valid,
  output logic [W-1:0]    o_out_data,
  output logic [SELW-1:0] o_out_ch,
  input  logic            i_out_ready
`ifdef MUXN_PARITY_EN
  ,
  output logic            o_out_par
`endif
);

  logic            r_outValid;
  logic [W-1:0]    r_outData;
  logic [SELW-1:0] r_outCh;
  logic [SELW-1:0] r_rrPtr;

  logic            w_canAccept;
  logic            w_grantValid;
  logic [SELW-1:0] w_grant;
  logic            w_hiValid;
  logic [SELW-1:0] w_hiIdx;
  logic            w_anyValid;
  logic [SELW-1:0] w_anyIdx;
  logic            w_xfer;
  logic [W-1:0]    w_selData;

  assign w_canAccept = !r_outValid || i_out_ready;

  // Round-robin: lowest requester at or above the pointer, else lowest overall (wrap).
  always_comb begin
    w_hiValid  = 1'b0;
    w_hiIdx    = '0;
    w_anyValid = 1'b0;
    w_anyIdx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_in_valid[i]) begin
        w_anyValid = 1'b1;
        w_anyIdx   = SELW'(i);
        if (SELW'(i) >= r_rrPtr) begin
          w_hiValid = 1'b1;
          w_hiIdx   = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    w_grantValid = 1'b0;
    w_grant      = '0;
    if (i_mode) begin
      w_grantValid = w_anyValid;
      w_grant      = w_hiValid ? w_hiIdx : w_anyIdx;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_sel == SELW'(i) && i_in_valid[i]) begin
          w_grantValid = 1'b1;
          w_grant      = SELW'(i);
        end
      end
    end
  end

  assign w_xfer = w_grantValid && w_canAccept && i_rst_n;

  always_comb begin
    o_in_ready = '0;
    w_selData  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        o_in_ready[i] = w_xfer;
        w_selData     = i_in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
      r_rrPtr    <= '0;
    end else if (w_xfer) begin
      r_outValid <= 1'b1;
      r_outData  <= w_selData;
      r_outCh    <= w_grant;
      r_rrPtr    <= (w_grant == SELW'(N - 1)) ? '0 : w_grant + SELW'(1);
    end else if (i_out_ready) begin
      r_outValid <= 1'b0;
    end
  end

`ifdef MUXN_PARITY_EN
  logic r_outPar;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_outPar <= 1'b0;
    end else if (w_xfer) begin
      r_outPar <= ^w_selData;
    end
  end

  assign o_out_par = r_outPar;
`endif

  assign o_out_valid = r_outValid;
  assign o_out_data  = r_outData;
  assign o_out_ch    = r_outCh;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Directed table-driven bench for mux_n_1_rr (N=4, W=8), plus hand sequences;
// parity checks are active when MUXN_PARITY_EN is defined.
module tb_mux_n_1_rr;

  localparam int N = 4;
  localparam int W = 8;
  localparam int NV = 24;

  logic         clk = 1'b0;
  logic         rstN;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   inValid;
  logic [31:0]  inData;
  logic [3:0]   inReady;
  logic         outValid;
  logic [7:0]   outData;
  logic [1:0]   outCh;
  logic         outReady;
`ifdef MUXN_PARITY_EN
  logic         outPar;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_1_rr #(.N(N), .W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_mode      (mode),
    .i_sel       (sel),
    .i_in_valid  (inValid),
    .i_in_data   (inData),
    .o_in_ready  (inReady),
    .o_out_valid (outValid),
    .o_out_data  (outData),
    .o_out_ch    (outCh),
    .i_out_ready (outReady)
`ifdef MUXN_PARITY_EN
    ,
    .o_out_par   (outPar)
`endif
  );

  typedef struct {
    logic        rstN;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        oRdy;
    logic [31:0] data;
    logic [3:0]  expRdy;
    logic        expV;
    logic [7:0]  expD;
    logic [1:0]  expCh;
  } vec_t;

  vec_t vecs[NV];

  localparam logic [31:0] D  = 32'h13121110;
  localparam logic [31:0] DA = 32'h13A51110;

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstN     = v.rstN;
    mode     = v.mode;
    sel      = v.sel;
    inValid  = v.iv;
    outReady = v.oRdy;
    inData   = v.data;
  endtask

  initial begin
    //            rst mode sel iv      ordy data  expRdy  V  data   ch
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, D,  4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, D,  4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 4'b0110, 1'b1, DA, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 4'b0110, 1'b1, DA, 4'b0000, 1'b0, 8'hA5, 2'd2};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[10] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, D,  4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, D,  4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[13] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, D,  4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[14] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[15] = '{1'b1, 1'b1, 2'd0, 4'b1000, 1'b1, D,  4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[16] = '{1'b1, 1'b1, 2'd0, 4'b1001, 1'b1, D,  4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[17] = '{1'b1, 1'b1, 2'd0, 4'b1001, 1'b1, D,  4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[18] = '{1'b1, 1'b1, 2'd0, 4'b1001, 1'b1, D,  4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[19] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[20] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[21] = '{1'b1, 1'b0, 2'd1, 4'b1111, 1'b0, D,  4'b0000, 1'b1, 8'h10, 2'd0};
    vecs[22] = '{1'b1, 1'b0, 2'd1, 4'b1111, 1'b1, D,  4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[23] = '{1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, D,  4'b0000, 1'b0, 8'h11, 2'd1};

    applyStimulus(vecs[0]);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput("in_ready", i, 32'(inReady), 32'(vecs[i].expRdy));
      @(posedge clk);
      #1;
      checkOutput("out_valid", i, 32'(outValid), 32'(vecs[i].expV));
      checkOutput("out_data",  i, 32'(outData),  32'(vecs[i].expD));
      checkOutput("out_ch",    i, 32'(outCh),    32'(vecs[i].expCh));
    end

    // Pointer sits at 2 with only ch1 requesting: grant must wrap round to ch1.
    begin
      int waited;
      mode     = 1'b1;
      inValid  = 4'b0010;
      outReady = 1'b1;
      inData   = D;
      #2;
      checkOutput("wrap_ready", 100, 32'(inReady), 32'h2);
      waited = 0;
      @(posedge clk);
      #1;
      inValid = 4'b0000;
      while (!outValid && waited < 5) begin
        @(posedge clk);
        #1;
        waited++;
      end
      checkOutput("wrap_timeout", 100, 32'(waited < 5), 32'h1);
      checkOutput("wrap_data", 100, 32'(outData), 32'h11);
      checkOutput("wrap_ch",   100, 32'(outCh),   32'h1);
    end

`ifdef MUXN_PARITY_EN
    mode     = 1'b0;
    sel      = 2'd0;
    inValid  = 4'b0001;
    outReady = 1'b1;
    inData   = 32'h13121107;
    @(posedge clk);
    #1;
    checkOutput("par_data07", 200, 32'(outData), 32'h07);
    checkOutput("par_07",     200, 32'(outPar),  32'h1);
    inData = 32'h13121103;
    @(posedge clk);
    #1;
    checkOutput("par_data03", 201, 32'(outData), 32'h03);
    checkOutput("par_03",     201, 32'(outPar),  32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
